fir_decim_mc: RTL

Multi-channel, run-time-programmable decimating FIR core for the FM radio datapath. It generalises the single-channel fixed-coefficient channel filter in three ways: interleaved channels, loadable coefficients and a configurable fixed-point scale. It sits between an upstream first-word-fall-through (FWFT) FIFO, such as the demodulator output, and a downstream FIFO, such as the audio LPR/LMR path. It produces one filtered sample per channel for every DECIMATION input frames.

---
 rtl/fir_decim_mc.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fir_decim_mc.sv
// fir_decim_mc: multi-channel decimating FIR with loadable shared coefficients.
// One serial MAC walks each channel's history once every DECIMATION frames.
module fir_decim_mc #(
  parameter int TAPS       = 32,
  parameter int DECIMATION = 8,
  parameter int CHANNELS   = 2,
  parameter int DATA_SIZE  = 32,
  parameter int FRAC_BITS  = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_empty,
  output logic                    in_rd_en,
  input  logic [DATA_SIZE-1:0]    in_dout,
  input  logic                    out_full,
  output logic                    out_wr_en,
  output logic [DATA_SIZE-1:0]    out_din,
  input  logic                    coeff_wr_en,
  input  logic [$clog2(TAPS)-1:0] coeff_addr,
  input  logic [DATA_SIZE-1:0]    coeff_din,
  output logic                    busy
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DEC_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int PW    = 2 * DATA_SIZE;

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIMATION - 1);
  localparam logic signed [PW-1:0] BIAS =
    (PW'(1) << FRAC_BITS) - PW'(1);

  typedef enum logic [1:0] {
    S_READ,
    S_MAC,
    S_WRITE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CH_W-1:0]      rd_ch;
  logic [DEC_W-1:0]     frame;
  logic [CH_W-1:0]      mac_ch;
  logic [TAP_W-1:0]     tap;
  logic [DATA_SIZE-1:0] acc;

  logic [DATA_SIZE-1:0] coeff [TAPS];
  logic [DATA_SIZE-1:0] hist  [CHANNELS][TAPS];

  logic frame_done;
  logic last_tap;
  logic last_ch;
  logic coeff_we;

  logic signed [DATA_SIZE-1:0] h_k;
  logic signed [DATA_SIZE-1:0] x_k;
  logic signed [PW-1:0]        prod;
  logic signed [PW-1:0]        prod_adj;
  logic [DATA_SIZE-1:0]        term;
  logic [DATA_SIZE-1:0]        acc_next;

  assign frame_done = in_rd_en
                   && (rd_ch == CH_LAST)
                   && (frame == DEC_LAST);
  assign last_tap = (tap == TAP_LAST);
  assign last_ch  = (mac_ch == CH_LAST);
  assign coeff_we = coeff_wr_en && !busy
                 && (int'(coeff_addr) < TAPS);

  always_comb begin
    state_nx  = state;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_READ: begin
        busy     = 1'b0;
        in_rd_en = !in_empty && reset;
        if (frame_done) state_nx = S_MAC;
      end
      S_MAC: begin
        if (last_tap) state_nx = S_WRITE;
      end
      S_WRITE: begin
        out_wr_en = !out_full;
        if (out_wr_en) state_nx = last_ch ? S_READ : S_MAC;
      end
      default: state_nx = S_READ;
    endcase
  end

  // Bias negative products so the arithmetic shift truncates toward zero.
  always_comb begin
    h_k      = coeff[tap];
    x_k      = hist[mac_ch][tap];
    prod     = PW'(h_k) * PW'(x_k);
    prod_adj = prod + (prod[PW-1] ? BIAS : '0);
    term     = DATA_SIZE'(prod_adj >>> FRAC_BITS);
    acc_next = acc + term;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_READ;
      rd_ch   <= '0;
      frame   <= '0;
      mac_ch  <= '0;
      tap     <= '0;
      acc     <= '0;
      out_din <= '0;
    end else begin
      state <= state_nx;
      if (in_rd_en) begin
        rd_ch <= (rd_ch == CH_LAST) ? '0 : rd_ch + CH_W'(1);
        if (rd_ch == CH_LAST)
          frame <= (frame == DEC_LAST) ? '0 : frame + DEC_W'(1);
      end
      unique case (state)
        S_READ: begin
          if (frame_done) begin
            mac_ch <= '0;
            tap    <= '0;
            acc    <= '0;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          tap <= last_tap ? '0 : tap + TAP_W'(1);
          if (last_tap) out_din <= acc_next;
        end
        S_WRITE: begin
          if (out_wr_en && !last_ch) begin
            mac_ch <= mac_ch + CH_W'(1);
            tap    <= '0;
            acc    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) coeff[k] <= '0;
    end else if (coeff_we) begin
      coeff[coeff_addr] <= coeff_din;
    end
  end

  // Newest sample lives at index 0 of its channel's history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) hist[c][k] <= '0;
    end else if (in_rd_en) begin
      for (int k = TAPS - 1; k > 0; k--)
        hist[rd_ch][k] <= hist[rd_ch][k-1];
      hist[rd_ch][0] <= in_dout;
    end
  end

endmodule
